// File: rtl/eif_pkg.sv
// eif_pkg: shared widths, saturation patterns and FIFO entry layout for the EIF spike monitor (entry gains peak with EIF_MON_PEAK_EN)
package eif_pkg;
  localparam int STATE_W = 8;
  localparam int ISI_W = 16;
  localparam logic [63:0] ISI_SAT = '1;
  localparam logic [7:0] RATE_SAT = 8'hff;
`ifdef EIF_MON_PEAK_EN
  typedef struct packed {
    logic [ISI_W-1:0] isi;
    logic [STATE_W-1:0] peak;
  } entry_t;
`else
  typedef struct packed {
    logic [ISI_W-1:0] isi;
  } entry_t;
`endif
endpackage

// File: rtl/eif_sync_fifo.sv
// eif_sync_fifo: circular FIFO with extra-bit pointers, gated head, occupancy and full/empty flags
module eif_sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign level = wr_ptr - rd_ptr;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, wr_en};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, rd_en};
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/eif_spike_monitor.sv
// eif_spike_monitor: spike onset ISI capture into a FIFO plus windowed rate; EIF_MON_PEAK_EN adds per-interval peak state
module eif_spike_monitor import eif_pkg::*; #(
  parameter int CNT_W = ISI_W,
  parameter int DEPTH = 8,
  parameter int WIN_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spike_in,
  input  logic [STATE_W-1:0]     state_in,
  input  logic                   clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       out_isi,
`ifdef EIF_MON_PEAK_EN
  output logic [STATE_W-1:0]     out_peak,
`endif
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             rate
);
  localparam int EW = CNT_W + $bits(entry_t) - ISI_W;
  localparam logic [CNT_W-1:0] ISI_MAX = ISI_SAT[CNT_W-1:0];
  logic spike_q, armed, onset, push, pop, full, empty;
  logic [CNT_W-1:0] isi_cnt, isi_nxt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0] spk_cnt, spk_nxt;
  logic [EW-1:0] din, head;
  assign onset = spike_in & ~spike_q;
  assign push = onset & armed & ~clr;
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  assign isi_nxt = isi_cnt == ISI_MAX ? ISI_MAX : isi_cnt + 1'b1;
  assign spk_nxt = spk_cnt == RATE_SAT ? RATE_SAT : spk_cnt + 8'(onset);
`ifdef EIF_MON_PEAK_EN
  logic [STATE_W-1:0] peak, peak_cur;
  assign peak_cur = state_in > peak ? state_in : peak;
  assign din = {isi_nxt, peak_cur};
  assign out_isi = head[EW-1 -: CNT_W];
  assign out_peak = head[STATE_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) peak <= '0;
    else peak <= onset ? state_in : peak_cur;
`else
  logic unused_state;
  assign unused_state = ^state_in;
  assign din = isi_nxt;
  assign out_isi = head;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spike_q <= 1'b0;
      armed <= 1'b0;
      isi_cnt <= '0;
      overflow <= 1'b0;
      win_cnt <= '0;
      spk_cnt <= '0;
      rate <= '0;
    end else begin
      spike_q <= spike_in;
      armed <= ~clr & (armed | onset);
      isi_cnt <= (clr | onset) ? '0 : isi_nxt;
      overflow <= ~clr & (overflow | (push & full & ~pop));
      win_cnt <= win_cnt + 1'b1;
      spk_cnt <= &win_cnt ? '0 : spk_nxt;
      rate <= &win_cnt ? spk_nxt : rate;
    end
  eif_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .clr(clr),
    .din(din),
    .head(head),
    .level(level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_eif_spike_monitor.sv
// tb_eif_spike_monitor: directed scenarios with hand-computed ISI, occupancy, overflow and rate expectations
module tb_eif_spike_monitor;
  logic clk, rst_n, spike_in, clr, out_ready;
  logic [7:0] state_in;
  logic out_valid, overflow;
  logic [15:0] out_isi;
  logic [3:0] level;
  logic [7:0] rate;
`ifdef EIF_MON_PEAK_EN
  logic [7:0] out_peak;
`endif
  int vecs = 0, errs = 0;

  eif_spike_monitor #(.CNT_W(16), .DEPTH(8), .WIN_LOG2(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spike_in(spike_in),
    .state_in(state_in),
    .clr(clr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_isi(out_isi),
`ifdef EIF_MON_PEAK_EN
    .out_peak(out_peak),
`endif
    .level(level),
    .overflow(overflow),
    .rate(rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse(input int gap, input bit rdy);
    spike_in = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    spike_in = 1'b0;
    out_ready = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0d want 0", out_valid); end
    vecs++; if (out_isi !== 16'd0) begin errs++; $display("FAIL rst_isi got %0d want 0", out_isi); end
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL rst_level got %0d want 0", level); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow got %0d want 0", overflow); end
    vecs++; if (rate !== 8'd0) begin errs++; $display("FAIL rst_rate got %0d want 0", rate); end
`ifdef EIF_MON_PEAK_EN
    vecs++; if (out_peak !== 8'd0) begin errs++; $display("FAIL rst_peak got %0d want 0", out_peak); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_clr();
    for (int c = 0; c <= 140; c++) begin
      if (c == 35) begin
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_valid35 got %0d want 0", out_valid); end
      end
      if (c == 36) begin
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid36 got %0d want 1", out_valid); end
        vecs++; if (out_isi !== 16'd25) begin errs++; $display("FAIL basic_isi36 got %0d want 25", out_isi); end
      end
      spike_in = (c == 10 || c == 35 || c == 135);
      @(negedge clk);
    end
    vecs++; if (level !== 4'd2) begin errs++; $display("FAIL basic_level got %0d want 2", level); end
    vecs++; if (out_isi !== 16'd25) begin errs++; $display("FAIL basic_head1 got %0d want 25", out_isi); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (out_isi !== 16'd100) begin errs++; $display("FAIL basic_head2 got %0d want 100", out_isi); end
    vecs++; if (level !== 4'd1) begin errs++; $display("FAIL basic_level1 got %0d want 1", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0 || level !== 4'd0) begin errs++; $display("FAIL basic_drain got valid=%0d level=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_held();
    do_clr();
    for (int c = 0; c <= 44; c++) begin
      spike_in = (c < 5) || (c == 40);
      @(negedge clk);
    end
    vecs++; if (level !== 4'd1) begin errs++; $display("FAIL held_level got %0d want 1", level); end
    vecs++; if (out_isi !== 16'd40) begin errs++; $display("FAIL held_isi got %0d want 40", out_isi); end
    do_clr();
  endtask

  task automatic test_level1_pushpop();
    do_clr();
    pulse(6, 1'b0);
    pulse(9, 1'b0);
    vecs++; if (level !== 4'd1 || out_isi !== 16'd6) begin errs++; $display("FAIL l1_pre got level=%0d isi=%0d want 1/6", level, out_isi); end
    pulse(1, 1'b1);
    vecs++; if (level !== 4'd1) begin errs++; $display("FAIL l1_level got %0d want 1", level); end
    vecs++; if (out_isi !== 16'd9) begin errs++; $display("FAIL l1_head got %0d want 9", out_isi); end
    do_clr();
  endtask

  task automatic test_overflow();
    do_clr();
    for (int g = 3; g <= 12; g++) pulse(g, 1'b0);
    pulse(1, 1'b0);
    vecs++; if (level !== 4'd8) begin errs++; $display("FAIL ovf_level got %0d want 8", level); end
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %0d want 1", overflow); end
    for (int k = 0; k < 8; k++) begin
      vecs++; if (out_isi !== 16'(3 + k)) begin errs++; $display("FAIL ovf_drain%0d got %0d want %0d", k, out_isi, 3 + k); end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin errs++; $display("FAIL ovf_after got valid=%0d ovf=%0d want 0/1", out_valid, overflow); end
    pulse(5, 1'b0);
    vecs++; if (level !== 4'd1 || out_isi !== 16'd9) begin errs++; $display("FAIL ovf_refill got level=%0d isi=%0d want 1/9", level, out_isi); end
    do_clr();
    vecs++; if (level !== 4'd0 || overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr got level=%0d ovf=%0d want 0/0", level, overflow); end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] exp_q [8];
    do_clr();
    pulse(20, 1'b0);
    for (int g = 21; g <= 27; g++) pulse(g, 1'b0);
    pulse(50, 1'b0);
    vecs++; if (level !== 4'd8 || overflow !== 1'b0) begin errs++; $display("FAIL fpp_pre got level=%0d ovf=%0d want 8/0", level, overflow); end
    pulse(1, 1'b1);
    vecs++; if (level !== 4'd8) begin errs++; $display("FAIL fpp_level got %0d want 8", level); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fpp_ovf got %0d want 0", overflow); end
    for (int k = 0; k < 7; k++) exp_q[k] = 16'(21 + k);
    exp_q[7] = 16'd50;
    for (int k = 0; k < 8; k++) begin
      vecs++; if (out_isi !== exp_q[k]) begin errs++; $display("FAIL fpp_drain%0d got %0d want %0d", k, out_isi, exp_q[k]); end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fpp_empty got %0d want 0", out_valid); end
  endtask

  task automatic test_clr_priority();
    do_clr();
    pulse(5, 1'b0);
    spike_in = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL clrp_nopush got %0d want 0", level); end
    pulse(7, 1'b0);
    vecs++; if (level !== 4'd0) begin errs++; $display("FAIL clrp_rearm got %0d want 0", level); end
    pulse(1, 1'b0);
    vecs++; if (level !== 4'd1 || out_isi !== 16'd7) begin errs++; $display("FAIL clrp_push got level=%0d isi=%0d want 1/7", level, out_isi); end
    do_clr();
  endtask

  task automatic test_saturation();
    do_clr();
    pulse(70000, 1'b0);
    pulse(1, 1'b0);
    vecs++; if (level !== 4'd1) begin errs++; $display("FAIL sat_level got %0d want 1", level); end
    vecs++; if (out_isi !== 16'd65535) begin errs++; $display("FAIL sat_isi got %0d want 65535", out_isi); end
    do_clr();
  endtask

  task automatic test_rate();
    do_clr();
    out_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      spike_in = (c % 2 == 0);
      @(negedge clk);
    end
    vecs++; if (rate !== 8'd8) begin errs++; $display("FAIL rate_a got %0d want 8", rate); end
    for (int c = 0; c < 16; c++) begin
      spike_in = (c % 2 == 0);
      @(negedge clk);
    end
    vecs++; if (rate !== 8'd8) begin errs++; $display("FAIL rate_b got %0d want 8", rate); end
    spike_in = 1'b0;
    repeat (32) @(negedge clk);
    vecs++; if (rate !== 8'd0) begin errs++; $display("FAIL rate_idle got %0d want 0", rate); end
    out_ready = 1'b0;
    do_clr();
  endtask

`ifdef EIF_MON_PEAK_EN
  task automatic test_peak();
    do_clr();
    state_in = 8'd0;
    spike_in = 1'b1;
    for (int s = 1; s <= 200; s++) begin
      @(negedge clk);
      spike_in = 1'b0;
      state_in = 8'(s);
    end
    @(negedge clk);
    spike_in = 1'b1;
    state_in = 8'd0;
    @(negedge clk);
    spike_in = 1'b0;
    vecs++; if (out_peak !== 8'd200) begin errs++; $display("FAIL peak_val got %0d want 200", out_peak); end
    vecs++; if (out_isi !== 16'd201) begin errs++; $display("FAIL peak_isi got %0d want 201", out_isi); end
    do_clr();
  endtask
`endif

  task automatic test_async_reset();
    do_clr();
    pulse(4, 1'b0);
    pulse(4, 1'b0);
    pulse(1, 1'b0);
    vecs++; if (level !== 4'd2) begin errs++; $display("FAIL arst_pre got %0d want 2", level); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (level !== 4'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL arst_level got level=%0d valid=%0d want 0/0", level, out_valid); end
    vecs++; if (out_isi !== 16'd0) begin errs++; $display("FAIL arst_isi got %0d want 0", out_isi); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    spike_in = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;
    state_in = 8'd0;
    test_reset();
    test_basic();
    test_held();
    test_level1_pushpop();
    test_overflow();
    test_full_pushpop();
    test_clr_priority();
    test_rate();
`ifdef EIF_MON_PEAK_EN
    test_peak();
`endif
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
